spi_req_arbiter: RTL and testbench
==================================

Name: spi_req_arbiter

Overview:
- Shares one SPI master between NREQ requesters.
- Arbitrates round-robin and launches one frame per grant via a single-cycle start pulse.
- Tracks the master's load/busy line, captures the received word, and returns it with the requester id over a valid/ready response channel.
- Sits between application clients (ADC poller, DAC writer, ...) and the SPI master, adding an inter-frame gap and a stuck-bus watchdog.

Parameters:
- NREQ, 2, number of requesters (2..8)
- WIDTH, 13, SPI frame width in bits; must match the master
- GAP_CYCLES, 4, idle clk cycles enforced between the end of one frame and the next start (>=1)
- TIMEOUT, 65535, max clk cycles allowed in each wait state before the frame is aborted
- IDW, $clog2(NREQ) (min 1), requester id width (derived)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_data  in  NREQ*WIDTH  per-requester tx word; requester i uses bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant/accept; transfer occurs when req_valid[i] & req_ready[i]
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  received word
- rsp_id  out  IDW  index of the requester that owns this response
- rsp_error  out  1  frame aborted by watchdog; rsp_data = 0
- spi_st  out  1  start pulse to master
- spi_din  out  WIDTH  tx word to master, held stable from ISSUE until the next accept
- spi_load  in  1  master idle flag: 1 = idle, 0 = shifting
- spi_dout  in  WIDTH  master's captured rx word, valid after spi_load rises
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; rr pointer = NREQ-1, so requester 0 wins first.
  - Gap and timeout counters are 0.
  - Reset mid-frame drops the frame silently; no response is produced.
- IDLE:
  - If any req_valid is set, grant the first valid index searching upward from rr+1 (mod NREQ).
  - req_ready[g]=1 combinationally in IDLE for the granted index only.
  - On accept: latch spi_din <= req_data[g], latch id <= g, rr <= g, go to ISSUE.
- ISSUE:
  - spi_st=1 for exactly this one cycle; timeout counter cleared; go to WAIT_LOW.
- WAIT_LOW:
  - Wait for spi_load==0, then go to WAIT_HIGH with the counter cleared.
  - If the counter reaches TIMEOUT first, go to RESP with rsp_error=1.
- WAIT_HIGH:
  - Wait for spi_load==1, then go to SETTLE.
  - If the counter reaches TIMEOUT first, go to RESP with rsp_error=1.
- SETTLE:
  - One cycle; spi_dout is sampled at the end of this cycle into rsp_data.
  - This covers the master's load-edge capture of the rx word.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_error are held stable until rsp_ready=1.
  - On handshake: rsp_valid drops the next cycle; go to GAP with the counter loaded to GAP_CYCLES-1.
- GAP:
  - Count down to 0, then go to IDLE.
  - No req_ready is asserted during GAP.
- Latency, idle bus with rsp_ready held high:
  - accept (cycle 0) -> spi_st (cycle 1) -> ... -> rsp_valid rises 2 cycles after spi_load returns high.
  - Next accept is possible GAP_CYCLES+1 cycles after the response handshake.
- Arbitration:
  - Strict round-robin on accepted grants.
  - A requester dropping req_valid before accept simply loses its turn; no state changes.
  - req_ready is never asserted to more than one index.
- Simultaneous events:
  - rsp_ready asserted before rsp_valid has no effect.
  - A req_valid change during a frame has no effect until IDLE.
- Watchdog counters saturate at TIMEOUT (16-bit minimum).
- Error responses still consume the GAP.

Test Plan:
1. Single request: req0 data 13'h1A5, a loopback master returns 13'h0F3 -> exactly one spi_st pulse, spi_din=13'h1A5, then rsp_valid with rsp_data=13'h0F3, rsp_id=0, rsp_error=0.
2. Round-robin: req0 and req1 held valid continuously for 4 frames -> grant order 0,1,0,1; rsp_id sequence matches; each next spi_st comes at least GAP_CYCLES=4 cycles after the prior response handshake.
3. Response backpressure: rsp_ready held low for 20 cycles -> rsp_valid/data/id stable for 20 cycles; no new req_ready and no spi_st until the handshake.
4. Stuck master: spi_load held at 1 after spi_st, with TIMEOUT=16 -> rsp_valid after 16 cycles in WAIT_LOW, rsp_error=1, rsp_data=0, then GAP, then IDLE.
5. Reset mid-frame: rst_n low during WAIT_HIGH -> all outputs 0 immediately; after release, no response is emitted and req0 is granted first.
6. Withdrawn request: req1 valid for one cycle while in GAP, then dropped -> no grant to req1; an idle bus stays in IDLE with busy=0.

Source files
------------

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one SPI master between NREQ requesters.
// A round-robin grant launches one frame with a single-cycle start pulse.
// The received word goes back with the owner's id on a valid/ready channel.
// An inter-frame gap and a stuck-bus watchdog are enforced between frames.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_data    per-requester request and tx word (i at [i*WIDTH +: WIDTH])
//   req_ready             one-hot grant, combinational in IDLE
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_id       received word and owning requester index
//   rsp_error             frame aborted by watchdog (rsp_data forced to 0)
//   spi_st/spi_din        start pulse and tx word to the SPI master
//   spi_load/spi_dout     master idle flag (1 = idle) and captured rx word
//   busy                  high whenever the arbiter is not in IDLE
module spi_req_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 65535,
  localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_error,
  output logic                    spi_st,
  output logic [WIDTH-1:0]        spi_din,
  input  logic                    spi_load,
  input  logic [WIDTH-1:0]        spi_dout,
  output logic                    busy
);

  // Shared gap/watchdog counter, never narrower than 16 bits.
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  TO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0]  GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [IDW-1:0] RR_RST   = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_SETTLE, S_RESP, S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [TW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] spi_din_q, spi_din_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_error_q, rsp_error_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             spi_st_q, spi_st_d;
  logic             busy_q, busy_d;

  logic             gnt_found_c;
  logic [IDW-1:0]   gnt_idx_c;
  logic [IDW-1:0]   cand_c;
  logic [WIDTH-1:0] gnt_data_c;
  logic             accept_c;

  // Round-robin search: first valid index upward from rr+1, wrapping at NREQ.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand_c = IDW'((32'(rr_q) + i) % NREQ);
      if (!gnt_found_c && req_valid[cand_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
  end

  // Tx word of the granted requester.
  always_comb begin
    gnt_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx_c == IDW'(i)) begin
        gnt_data_c = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant is only offered in IDLE; the search guarantees req_valid is set there.
  assign accept_c = (state_q == S_IDLE) && gnt_found_c;

  // One-hot grant; held at zero while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && accept_c) begin
      req_ready[gnt_idx_c] = 1'b1;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    rsp_id_d    = rsp_id_q;
    spi_din_d   = spi_din_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    cnt_inc     = (cnt_q == TO_MAX) ? cnt_q : cnt_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          spi_din_d = gnt_data_c;
          rsp_id_d  = gnt_idx_c;
          rr_d      = gnt_idx_c;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!spi_load) begin
          cnt_d   = '0;
          state_d = S_WAIT_HIGH;
        end else if (cnt_q >= TO_LAST) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_HIGH: begin
        if (spi_load) begin
          state_d = S_SETTLE;
        end else if (cnt_q >= TO_LAST) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SETTLE: begin
        // Master has had a full cycle to capture the rx word on its load edge.
        rsp_data_d  = spi_dout;
        rsp_error_d = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    spi_st_d    = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= RR_RST;
      cnt_q       <= '0;
      rsp_id_q    <= '0;
      spi_din_q   <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      spi_st_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      rsp_id_q    <= rsp_id_d;
      spi_din_q   <= spi_din_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      rsp_valid_q <= rsp_valid_d;
      spi_st_q    <= spi_st_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_error = rsp_error_q;
  assign spi_st    = spi_st_q;
  assign spi_din   = spi_din_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a behavioural SPI master model.
module tb_spi_req_arbiter;

  localparam int unsigned NREQ       = 2;
  localparam int unsigned WIDTH      = 13;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int unsigned TIMEOUT    = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [0:0]            rsp_id;
  logic                  rsp_error;
  logic                  spi_st;
  logic [WIDTH-1:0]      spi_din;
  logic                  spi_load;
  logic [WIDTH-1:0]      spi_dout;
  logic                  busy;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int st_count  = 0;
  int hs_count  = 0;
  int acc_cyc   = -1;
  int gnt_log[$];

  // Master model controls.
  bit               stuck     = 1'b0;
  bit               loop_inv  = 1'b0;
  int               shift_len = 5;
  logic [WIDTH-1:0] rx_word   = '0;

  spi_req_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_error(rsp_error),
    .spi_st(spi_st), .spi_din(spi_din), .spi_load(spi_load), .spi_dout(spi_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Event monitors.
  always @(negedge clk) begin
    if (spi_st === 1'b1) st_count++;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) hs_count++;
    if ((req_valid & req_ready) != '0) begin
      gnt_log.push_back(req_ready[1] ? 1 : 0);
      acc_cyc = cyc;
    end
  end

  // SPI master: load drops after the start pulse, rises shift_len cycles later.
  initial begin
    spi_load = 1'b1;
    spi_dout = '0;
    forever begin
      @(negedge clk);
      if (spi_st === 1'b1 && !stuck) begin
        spi_load = 1'b0;
        for (int i = 0; i < shift_len; i++) begin
          @(negedge clk);
          if (!rst_n) break;
        end
        spi_dout = loop_inv ? (spi_din ^ 13'h1FFF) : rx_word;
        spi_load = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin t = cyc; break; end
    end
  endtask

  task automatic wait_st(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (spi_st === 1'b1) begin t = cyc; break; end
    end
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy === 1'b0) begin t = cyc; break; end
    end
  endtask

  task automatic wait_ready(output int t);
    t = -1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (req_ready !== '0) begin t = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_tests++; if (spi_st !== 1'b0) begin n_fail++; $display("FAIL reset_spi_st: got %0b want 0", spi_st); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    n_tests++; if (spi_din !== '0 || rsp_data !== '0) begin
      n_fail++; $display("FAIL reset_data: spi_din=%h rsp_data=%h want 0", spi_din, rsp_data); end
    rst_n = 1'b1;
    tick();
    n_tests++; if (req_ready !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: req_ready=%b busy=%0b want 00/0", req_ready, busy); end
  endtask

  task automatic test_round_robin();
    int t, s;
    logic [0:0]       exp_id;
    logic [WIDTH-1:0] exp_data;
    loop_inv = 1'b1; shift_len = 5; rsp_ready = 1'b1;
    gnt_log.delete();
    at_pos();
    req_data  = {13'h155, 13'h0AA};
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_rsp(t);
      exp_id   = (f % 2 == 1) ? 1'b1 : 1'b0;
      exp_data = (f % 2 == 1) ? 13'h1EAA : 13'h1F55;
      n_tests++;
      if (t < 0 || rsp_id !== exp_id || rsp_data !== exp_data || rsp_error !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: t=%0d id=%0d data=%h err=%0b want id=%0d data=%h err=0",
                 f, t, rsp_id, rsp_data, rsp_error, exp_id, exp_data);
      end
      if (f == 3) begin
        at_pos();
        req_valid = 2'b00;
      end else begin
        wait_st(s);
        n_tests++;
        if (s < 0 || s - t != 6) begin
          n_fail++; $display("FAIL rr_gap%0d: spi_st %0d cycles after handshake, want 6", f, s - t);
        end
      end
    end
    wait_idle(t);
    n_tests++;
    if (t < 0 || gnt_log.size() != 4 || gnt_log[0] != 0 || gnt_log[1] != 1 ||
        gnt_log[2] != 0 || gnt_log[3] != 1) begin
      n_fail++; $display("FAIL rr_order: got %p want '{0,1,0,1}", gnt_log);
    end
    loop_inv = 1'b0;
  endtask

  task automatic test_single();
    int t, st0;
    rx_word = 13'h0F3; shift_len = 5; rsp_ready = 1'b1;
    st0 = st_count;
    at_pos();
    req_data  = {13'h000, 13'h1A5};
    req_valid = 2'b01;
    wait_ready(t);
    n_tests++;
    if (t < 0 || req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_grant: req_ready=%b want 01", req_ready); end
    at_pos();
    req_valid = 2'b00;
    wait_rsp(t);
    n_tests++;
    if (t < 0 || rsp_data !== 13'h0F3 || rsp_id !== 1'b0 || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: data=%h id=%0d err=%0b want 0f3/0/0", rsp_data, rsp_id, rsp_error); end
    n_tests++;
    if (spi_din !== 13'h1A5) begin
      n_fail++; $display("FAIL single_din: got %h want 1a5", spi_din); end
    n_tests++;
    if (st_count - st0 != 1) begin
      n_fail++; $display("FAIL single_st_count: got %0d want 1", st_count - st0); end
    n_tests++;
    if (t - acc_cyc != 8) begin
      n_fail++; $display("FAIL single_latency: accept->rsp_valid %0d cycles want 8", t - acc_cyc); end
    wait_idle(t);
    n_tests++; if (t < 0) begin n_fail++; $display("FAIL single_idle: busy=%0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int t, st0;
    rx_word = 13'h1234; shift_len = 5; rsp_ready = 1'b0;
    at_pos();
    req_data  = {13'h0456, 13'h0333};
    req_valid = 2'b11;
    wait_rsp(t);
    n_tests++;
    if (t < 0 || rsp_id !== 1'b1 || rsp_data !== 13'h1234) begin
      n_fail++; $display("FAIL bp_rsp: id=%0d data=%h want 1/1234", rsp_id, rsp_data); end
    st0 = st_count;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 13'h1234 || rsp_id !== 1'b1 || rsp_error !== 1'b0 ||
          req_ready !== 2'b00 || spi_st !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%0b data=%h id=%0d err=%0b ready=%b st=%0b want 1/1234/1/0/00/0",
                 i, rsp_valid, rsp_data, rsp_id, rsp_error, req_ready, spi_st);
      end
    end
    n_tests++;
    if (st_count != st0) begin n_fail++; $display("FAIL bp_no_start: %0d extra spi_st want 0", st_count - st0); end
    at_pos();
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    tick(); tick();
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: rsp_valid=%0b want 0", rsp_valid); end
    wait_idle(t);
  endtask

  task automatic test_stuck();
    int s, t, u;
    stuck = 1'b1; rsp_ready = 1'b1;
    at_pos();
    req_data  = {13'h0777, 13'h0000};
    req_valid = 2'b10;
    wait_st(s);
    at_pos();
    req_valid = 2'b00;
    wait_rsp(t);
    n_tests++;
    if (s < 0 || t < 0 || t - s != 17) begin
      n_fail++; $display("FAIL stuck_timing: rsp_valid %0d cycles after spi_st want 17", t - s); end
    n_tests++;
    if (rsp_error !== 1'b1 || rsp_data !== '0 || rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL stuck_rsp: err=%0b data=%h id=%0d want 1/0/1", rsp_error, rsp_data, rsp_id); end
    wait_idle(u);
    n_tests++;
    if (u < 0 || u - t != 5) begin
      n_fail++; $display("FAIL stuck_gap: idle %0d cycles after handshake want 5", u - t); end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s, t, hs0;
    shift_len = 10; rsp_ready = 1'b1;
    at_pos();
    req_data  = {13'h0000, 13'h0ABC};
    req_valid = 2'b01;
    wait_st(s);
    at_pos();
    req_valid = 2'b00;
    tick(); tick();
    n_tests++;
    if (busy !== 1'b1 || spi_load !== 1'b0) begin
      n_fail++; $display("FAIL rmid_setup: busy=%0b load=%0b want 1/0", busy, spi_load); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || spi_st !== 1'b0 || spi_din !== '0 || rsp_valid !== 1'b0 ||
        rsp_data !== '0 || rsp_id !== 1'b0 || rsp_error !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_outputs: busy=%0b st=%0b din=%h valid=%0b data=%h id=%0d err=%0b ready=%b want all 0",
               busy, spi_st, spi_din, rsp_valid, rsp_data, rsp_id, rsp_error, req_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    hs0 = hs_count;
    shift_len = 5; rx_word = 13'h0A0A;
    at_pos();
    req_data  = {13'h0111, 13'h0222};
    req_valid = 2'b11;
    wait_ready(t);
    n_tests++;
    if (t < 0 || req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rmid_first_grant: req_ready=%b want 01", req_ready); end
    at_pos();
    req_valid = 2'b00;
    wait_rsp(t);
    n_tests++;
    if (t < 0 || rsp_id !== 1'b0 || rsp_data !== 13'h0A0A || hs_count - hs0 != 1) begin
      n_fail++;
      $display("FAIL rmid_rsp: id=%0d data=%h responses=%0d want 0/0a0a/1", rsp_id, rsp_data, hs_count - hs0);
    end
    wait_idle(t);
  endtask

  task automatic test_withdrawn();
    int t, g0, st0;
    shift_len = 5; rsp_ready = 1'b1; rx_word = 13'h0055;
    at_pos();
    req_data  = {13'h0099, 13'h0042};
    req_valid = 2'b01;
    wait_ready(t);
    at_pos();
    req_valid = 2'b00;
    wait_rsp(t);
    n_tests++;
    if (t < 0 || rsp_data !== 13'h0055 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL wd_rsp: data=%h id=%0d want 0055/0", rsp_data, rsp_id); end
    g0  = gnt_log.size();
    st0 = st_count;
    at_pos();
    req_valid = 2'b10;
    tick();
    n_tests++;
    if (req_ready !== 2'b00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wd_gap_ready: req_ready=%b busy=%0b want 00/1", req_ready, busy); end
    at_pos();
    req_valid = 2'b00;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_tests++;
      if (req_ready !== 2'b00 || spi_st !== 1'b0) begin
        n_fail++; $display("FAIL wd_quiet%0d: req_ready=%b st=%0b want 00/0", i, req_ready, spi_st); end
    end
    n_tests++;
    if (busy !== 1'b0 || gnt_log.size() != g0 || st_count != st0) begin
      n_fail++;
      $display("FAIL wd_idle: busy=%0b new_grants=%0d new_starts=%0d want 0/0/0",
               busy, gnt_log.size() - g0, st_count - st0);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_stuck();
    test_reset_mid();
    test_withdrawn();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
